// File: rtl/exc_judger_pipe.sv
// ----------------------------------------------------------------------------
// exc_judger_pipe
//
// Purpose:
//   Classifies the instruction in the E stage against a configurable memory
//   map. The classes are interrupt, AdEL, AdES, RI and Ov. The resulting
//   ExcCode is registered into the M stage together with the valid bit and
//   the side data. A sticky capture register then holds the first M-stage
//   exception until CP0 acknowledges it. Exceptions that arrive while the
//   capture register is occupied are counted in a saturating counter.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   stall          hold the M registers
//   flush          load a bubble into M (valid=0, code=31); wins over stall
//   valid_E        E slot holds a real instruction
//   wrongpc_E      fetch PC misaligned or out of range
//   unknown_E      reserved instruction
//   overflow_E     ALU signed overflow
//   is_load_E      load instruction
//   is_store_E     store instruction
//   size_E         0 byte, 1 half, 2/3 word
//   alures_E       ALU result / effective address
//   pc_E, bd_E     instruction PC and delay-slot flag
//   int_req        external interrupt request
//   exc_ack        CP0 consumed the captured exception
//   code_M         M-stage ExcCode (0, 4, 5, 10, 12; 31 = none)
//   valid_M        M slot valid
//   exc_req        capture register holds an unacknowledged exception
//   exc_code       captured ExcCode
//   exc_epc        captured EPC (pc-4 for delay-slot instructions)
//   exc_badvaddr   captured faulting address
//   exc_bd         captured delay-slot flag
//   drop_cnt       saturating count of exceptions lost while exc_req=1
// ----------------------------------------------------------------------------
module exc_judger_pipe #(
    parameter logic [31:0]           DM_LIMIT   = 32'h0000_2fff,
    parameter int                    NUM_DEV    = 2,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE   = {32'h0000_7f10, 32'h0000_7f00},
    parameter int                    DEV_SPAN   = 12,
    parameter int                    DEV_RO_OFF = 8,
    parameter int                    DROP_W     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_E,
    input  logic              wrongpc_E,
    input  logic              unknown_E,
    input  logic              overflow_E,
    input  logic              is_load_E,
    input  logic              is_store_E,
    input  logic [1:0]        size_E,
    input  logic [31:0]       alures_E,
    input  logic [31:0]       pc_E,
    input  logic              bd_E,
    input  logic              int_req,
    input  logic              exc_ack,
    output logic [4:0]        code_M,
    output logic              valid_M,
    output logic              exc_req,
    output logic [4:0]        exc_code,
    output logic [31:0]       exc_epc,
    output logic [31:0]       exc_badvaddr,
    output logic              exc_bd,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;
    localparam logic [4:0] CODE_NONE = 5'd31;

    // ------------------------------------------------------------------
    // Device window decode. The compares are done on 33 bits, so a window
    // near the top of the address space does not wrap around to 0.
    // ------------------------------------------------------------------
    logic [NUM_DEV-1:0] dev_hit;
    logic [NUM_DEV-1:0] dev_ro;

    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] addr;
        logic [32:0] off;
        assign lo          = {1'b0, DEV_BASE[gi*32 +: 32]};
        assign hi          = lo + 33'(DEV_SPAN) - 33'd1;
        assign addr        = {1'b0, alures_E};
        assign off         = addr - lo;
        assign dev_hit[gi] = (addr >= lo) && (addr <= hi);
        assign dev_ro[gi]  = dev_hit[gi] && (off >= 33'(DEV_RO_OFF));
    end

    logic in_dm;
    logic in_dev;
    logic in_ro;
    logic is_word;
    logic misaligned;
    logic mem_bad;
    logic [4:0] code_e;

    assign in_dm   = (alures_E <= DM_LIMIT);
    assign in_dev  = |dev_hit;
    assign in_ro   = |dev_ro;
    // A size of 3 is illegal and is treated as a word access.
    assign is_word = size_E[1];

    always_comb begin
        misaligned = 1'b0;
        if (is_word)
            misaligned = (alures_E[1:0] != 2'b00);
        else if (size_E == 2'd1)
            misaligned = alures_E[0];
    end

    // These fault rules are shared by loads and stores. A store has one
    // more rule: a read-only device offset also faults.
    assign mem_bad = misaligned || overflow_E || !(in_dm || in_dev) ||
                     (in_dev && !is_word);

    // Priority chain. The first match wins.
    always_comb begin
        code_e = CODE_NONE;
        if (!valid_E)
            code_e = CODE_NONE;
        else if (int_req)
            code_e = CODE_INT;
        else if (wrongpc_E)
            code_e = CODE_ADEL;
        else if (is_load_E && mem_bad)
            code_e = CODE_ADEL;
        else if (is_store_E && (mem_bad || in_ro))
            code_e = CODE_ADES;
        else if (unknown_E)
            code_e = CODE_RI;
        else if (overflow_E)
            code_e = CODE_OV;
    end

    // ------------------------------------------------------------------
    // E->M register
    // ------------------------------------------------------------------
    logic [4:0]  code_m_q;
    logic        valid_m_q;
    logic [31:0] pc_m_q;
    logic        bd_m_q;
    logic [31:0] bad_m_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_m_q  <= CODE_NONE;
            valid_m_q <= 1'b0;
            pc_m_q    <= '0;
            bd_m_q    <= 1'b0;
            bad_m_q   <= '0;
        end else if (flush) begin
            code_m_q  <= CODE_NONE;
            valid_m_q <= 1'b0;
            pc_m_q    <= '0;
            bd_m_q    <= 1'b0;
            bad_m_q   <= '0;
        end else if (!stall) begin
            code_m_q  <= code_e;
            valid_m_q <= valid_E;
            pc_m_q    <= pc_E;
            bd_m_q    <= bd_E;
            // A fetch fault reports the PC. Any other fault reports the
            // effective address.
            bad_m_q   <= wrongpc_E ? pc_E : alures_E;
        end
    end

    assign code_M  = code_m_q;
    assign valid_M = valid_m_q;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    typedef enum logic {IDLE, HELD} cap_state_t;

    cap_state_t        state_q;
    logic              exc_req_q;
    logic [4:0]        exc_code_q;
    logic [31:0]       exc_epc_q;
    logic [31:0]       exc_bad_q;
    logic              exc_bd_q;
    logic [DROP_W-1:0] drop_q;

    logic        m_exc;
    logic [31:0] epc_d;

    assign m_exc = valid_m_q && (code_m_q != CODE_NONE);
    assign epc_d = bd_m_q ? (pc_m_q - 32'd4) : pc_m_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            exc_req_q  <= 1'b0;
            exc_code_q <= CODE_NONE;
            exc_epc_q  <= '0;
            exc_bad_q  <= '0;
            exc_bd_q   <= 1'b0;
            drop_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_exc) begin
                        state_q    <= HELD;
                        exc_req_q  <= 1'b1;
                        exc_code_q <= code_m_q;
                        exc_epc_q  <= epc_d;
                        exc_bad_q  <= bad_m_q;
                        exc_bd_q   <= bd_m_q;
                    end
                end
                HELD: begin
                    if (exc_ack) begin
                        // A new exception in the cycle of the ack is taken
                        // directly, with no pass through IDLE.
                        if (m_exc) begin
                            exc_code_q <= code_m_q;
                            exc_epc_q  <= epc_d;
                            exc_bad_q  <= bad_m_q;
                            exc_bd_q   <= bd_m_q;
                        end else begin
                            state_q   <= IDLE;
                            exc_req_q <= 1'b0;
                        end
                    end else if (m_exc && (drop_q != {DROP_W{1'b1}})) begin
                        drop_q <= drop_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    exc_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign exc_req      = exc_req_q;
    assign exc_code     = exc_code_q;
    assign exc_epc      = exc_epc_q;
    assign exc_badvaddr = exc_bad_q;
    assign exc_bd       = exc_bd_q;
    assign drop_cnt     = drop_q;

endmodule
